// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter, one log2 shift stage per register.
// Single global advance enable; flush drops all in-flight operations.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_bad_op
);

    localparam int SHW = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("barrel_shifter_pipe: WIDTH must be a power of 2 and >= 2");
    end

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic             vld [SHW];
    logic [WIDTH-1:0] dat [SHW];
    logic [SHW-1:0]   amt [SHW];
    logic [2:0]       opr [SHW];
    logic [TAG_W-1:0] tg  [SHW];
    logic             sgn [SHW];
    logic [WIDTH-1:0] nxt [SHW];
    logic             en;

    // One partial shift by s; sign is the original operand MSB for SRA.
    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input logic             do_sh,
        input int               s
    );
        logic [2*WIDTH-1:0] w;
        logic [WIDTH-1:0]   r;
        w = '0;
        r = d;
        if (do_sh) begin
            case (op)
                OP_SLL: r = d << s;
                OP_SRL: r = d >> s;
                OP_SRA: begin
                    w = {{WIDTH{sign}}, d} >> s;
                    r = w[WIDTH-1:0];
                end
                OP_ROL: begin
                    w = {d, d} << s;
                    r = w[2*WIDTH-1:WIDTH];
                end
                OP_ROR: begin
                    w = {d, d} >> s;
                    r = w[WIDTH-1:0];
                end
                default: r = d;
            endcase
        end
        return r;
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Next data for each stage: largest amount bit is applied first.
    always_comb begin
        nxt[0] = step(in_data, in_op, in_data[WIDTH-1],
                      in_amt[SHW-1], 1 << (SHW - 1));
        for (int k = 1; k < SHW; k++) begin
            nxt[k] = step(dat[k-1], opr[k-1], sgn[k-1],
                          amt[k-1][SHW-1-k], 1 << (SHW - 1 - k));
        end
    end

    // Valid bits: flush clears all, otherwise advance on en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) vld[k] <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < SHW; k++) vld[k] <= 1'b0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int k = 1; k < SHW; k++) vld[k] <= vld[k-1];
        end
    end

    // Payload registers advance together on en; contents of bubbles are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                dat[k] <= '0;
                amt[k] <= '0;
                opr[k] <= OP_SLL;
                tg[k]  <= '0;
                sgn[k] <= 1'b0;
            end
        end else if (en) begin
            dat[0] <= nxt[0];
            amt[0] <= in_amt;
            opr[0] <= in_op;
            tg[0]  <= in_tag;
            sgn[0] <= in_data[WIDTH-1];
            for (int k = 1; k < SHW; k++) begin
                dat[k] <= nxt[k];
                amt[k] <= amt[k-1];
                opr[k] <= opr[k-1];
                tg[k]  <= tg[k-1];
                sgn[k] <= sgn[k-1];
            end
        end
    end

    assign out_valid  = vld[SHW-1];
    assign out_data   = dat[SHW-1];
    assign out_tag    = tg[SHW-1];
    assign out_zero   = (dat[SHW-1] == '0);
    assign out_bad_op = (opr[SHW-1] > OP_ROR);

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined, multi-mode barrel shifter with valid/ready flow control. It performs logical left/right, arithmetic right, rotate left and rotate right on a WIDTH-bit word, one log2 stage per pipeline register. A sideband tag travels with each word. It is the clocked, streaming successor to the combinational 8-bit right-rotate shifters and sits between datapath producers and consumers that need a shift unit sustaining one operation per clock.

## Interface
- WIDTH, 8: data width. Must be a power of 2 and ≥ 2. SHW = $clog2(WIDTH) is derived locally, not a parameter.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; invalidates all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 pass-through.
- in_tag  in  TAG_W  user sideband, returned unmodified.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the operation in out_data.
- out_zero  out  1  out_data == 0.
- out_bad_op  out  1  in_op was 101–111; out_data equals the operand.

## Operation
- The pipeline has SHW stage registers, S0..S(SHW-1). Stage k applies the shift of 2^(SHW-1-k) when amt bit (SHW-1-k) is set, so the largest amount bit is applied first.
- Each stage register holds: valid, data, remaining amt bits, op, tag.
- The output fields are driven directly from S(SHW-1).
- Fill rules:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: fill with the original operand MSB. The sign bit is captured in S0 and carried through the stages.
  - ROL/ROR: bits wrap; none are lost.
- Pass-through ops perform no shift regardless of amt and set out_bad_op.
- An amount of 0 returns the operand unchanged for every op.
- out_zero is computed from the final data. It is combinational from S(SHW-1) or registered alongside it; either way it must be valid whenever out_valid=1.

Flow control uses one global advance enable: en = !out_valid || out_ready.
- in_ready = en. This is a combinational path from out_ready and is permitted.
- When en=1, every stage loads from its predecessor, and S0 loads the input with valid = in_valid.
- When en=0, all stages hold, including bubbles. Bubbles are not collapsed.
- Once asserted, out_valid and all output fields stay stable until out_ready=1.

Flush:
- flush=1 clears the valid bit of every stage at the clock edge, regardless of en.
- An input presented in a flush cycle is dropped, even when in_valid && in_ready.
- Data and tag registers need not be cleared.

Reset:
- Asynchronous assertion clears all valid bits immediately.
- Reset outputs: out_valid=0, out_data=0, out_tag=0, out_zero=1, out_bad_op=0. in_ready=1 (follows en).
- Reset mid-operation discards all in-flight work. Nothing is emitted after deassertion until new inputs arrive.

## Timing
- Latency with no stall: an operation accepted at edge E0 is presented with out_valid=1 during the cycle after edge E(SHW-1). That is SHW cycles; 3 for WIDTH=8.
- Throughput: one operation per clock while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and nothing moves. At most SHW operations are in flight.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle are both honoured.
  - flush overrides any accept or advance in the same cycle.
  - rst_n low overrides everything.
- in_amt and in_op are sampled only on the accepting edge. Changes at any other time have no effect.

## Test plan
- WIDTH=8, in_data=0x96, in_amt=3, in_op SLL/SRL/SRA/ROL/ROR issued back to back with out_ready=1. Required: out_data 0xB0, 0x12, 0xF2, 0xB4, 0xD2, on consecutive cycles starting 3 cycles after the first accept, tags in order.
- in_data=0x01, in_amt=7, op ROR → 0x02. in_data=0x80, amt=7, op SRA → 0xFF. in_data=0x80, amt=0, op SRL → 0x80. data=0x10, amt=5, op SLL → 0x00 with out_zero=1.
- in_op=110, in_data=0x5A, in_amt=4 → out_data=0x5A, out_bad_op=1.
- Stream 6 ops with out_ready held low from cycle 2 for 5 cycles. Required:
  - out_valid/out_data/out_tag stay stable while stalled;
  - in_ready=0 while out_valid=1 and out_ready=0;
  - no op is lost or duplicated;
  - order is preserved.
- Fill the pipeline with 3 ops, then assert flush for 1 cycle with in_valid=1. Required: no outputs from any of those 4 ops; the next accepted op appears after 3 cycles.
- Assert rst_n low asynchronously mid-stream (between clock edges). Required: out_valid=0 immediately, out_data=0, out_zero=1. After release, no stale results appear.
